id_stage: RTL and testbench

Decode stage of the Eon-I in-order RV32I pipeline. Takes the instruction/PC pair registered by the fetch stage, decodes control fields and immediate, reads two operands from the architectural register file it owns, and registers the result for execute. It also accepts the writeback port and detects load-use hazards, raising a stall request back to fetch.

---
 rtl/eon_pkg.sv | 87 ++++++++
 rtl/eon_reg_file.sv | 42 ++++
 rtl/id_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_id_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eon_pkg.sv
// Shared decode types and constants for the Eon-I decode stage.
package eon_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcFence  = 7'b0001111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluPassB = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    WbAlu = 2'd0,
    WbMem = 2'd1,
    WbPc4 = 2'd2
  } wbsel_t;

  typedef struct packed {
    aluop_t alu_op;
    logic   alu_src_imm;
    logic   mem_read;
    logic   mem_write;
    logic   reg_write;
    logic   branch;
    logic   jump;
    logic   jalr;
    logic   illegal;
    wbsel_t wb_sel;
  } ctrl_t;

  localparam ctrl_t CtrlBubble = '{
    alu_op:      AluAdd,
    alu_src_imm: 1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    reg_write:   1'b0,
    branch:      1'b0,
    jump:        1'b0,
    jalr:        1'b0,
    illegal:     1'b0,
    wb_sel:      WbAlu
  };

  typedef struct packed {
    ctrl_t ctrl;
    logic  use_rs1;
    logic  use_rs2;
    logic  use_rd;
  } dec_t;

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful.
  function automatic aluop_t alu_decode(input logic [2:0] f3, input logic alt);
    aluop_t op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/eon_reg_file.sv
// Architectural register file: 2 async read ports, 1 sync write port, x0 hardwired to zero.
// Define EON_WB_BYPASS_EN to make a same-cycle write visible on the read ports.
module eon_reg_file
  import eon_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned RegCount = 32,
  localparam int unsigned AddrW   = $clog2(RegCount)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [AddrW-1:0] raddr1,
  input  logic [AddrW-1:0] raddr2,
  output logic [Width-1:0] rdata1,
  output logic [Width-1:0] rdata2,
  input  logic             wen,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata
);

  logic [Width-1:0] regs_q [RegCount];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < RegCount; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
`ifdef EON_WB_BYPASS_EN
    if (wen && (waddr != '0) && (waddr == raddr1)) rdata1 = wdata;
    if (wen && (waddr != '0) && (waddr == raddr2)) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// Eon-I decode stage: control/immediate decode, register read, load-use stall detection.
// Register-file write-through is enabled by defining EON_WB_BYPASS_EN.
module id_stage
  import eon_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned RegCount = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [Width-1:0] instructionIn,
  input  logic [Width-1:0] PCIn,
  input  logic             stall,
  input  logic             flush,
  input  logic             wbEn,
  input  logic [4:0]       wbRd,
  input  logic [Width-1:0] wbData,
  output logic             stallReq,
  output logic [Width-1:0] rs1DataOut,
  output logic [Width-1:0] rs2DataOut,
  output logic [Width-1:0] immOut,
  output logic [4:0]       rs1Out,
  output logic [4:0]       rs2Out,
  output logic [4:0]       rdOut,
  output logic [2:0]       funct3Out,
  output logic [3:0]       aluOpOut,
  output logic             aluSrcImmOut,
  output logic             memReadOut,
  output logic             memWriteOut,
  output logic             regWriteOut,
  output logic             branchOut,
  output logic             jumpOut,
  output logic             jalrOut,
  output logic             illegalOut,
  output logic [1:0]       wbSelOut,
  output logic [Width-1:0] PCOut
);

  function automatic logic [Width-1:0] gen_imm(input logic [Width-1:0] instr);
    logic [Width-1:0] imm;
    case (instr[6:0])
      OpcOpImm, OpcLoad, OpcJalr: imm = Width'($signed(instr[31:20]));
      OpcStore:  imm = Width'($signed({instr[31:25], instr[11:7]}));
      OpcBranch: imm = Width'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      OpcLui, OpcAuipc: imm = Width'($signed({instr[31:12], 12'b0}));
      OpcJal:    imm = Width'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default:   imm = '0;
    endcase
    return imm;
  endfunction

  function automatic dec_t decode(input logic [Width-1:0] instr);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = instr[14:12];
    f7 = instr[31:25];
    d  = '{ctrl: CtrlBubble, use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b0};
    if (instr[31:0] != NOP_INSTR) begin
      case (instr[6:0])
        OpcLui, OpcAuipc: begin
          d.ctrl.alu_op      = (instr[6:0] == OpcLui) ? AluPassB : AluAdd;
          d.ctrl.alu_src_imm = 1'b1;
          d.ctrl.reg_write   = 1'b1;
          d.use_rd           = 1'b1;
        end
        OpcJal: begin
          d.ctrl.alu_src_imm = 1'b1;
          d.ctrl.reg_write   = 1'b1;
          d.ctrl.jump        = 1'b1;
          d.ctrl.wb_sel      = WbPc4;
          d.use_rd           = 1'b1;
        end
        OpcJalr: begin
          d.ctrl.alu_src_imm = 1'b1;
          d.ctrl.reg_write   = 1'b1;
          d.ctrl.jalr        = 1'b1;
          d.ctrl.wb_sel      = WbPc4;
          d.ctrl.illegal     = (f3 != 3'b000);
          d.use_rd           = 1'b1;
          d.use_rs1          = 1'b1;
        end
        OpcBranch: begin
          d.ctrl.alu_op  = AluSub;
          d.ctrl.branch  = 1'b1;
          d.ctrl.illegal = (f3[2:1] == 2'b01);
          d.use_rs1      = 1'b1;
          d.use_rs2      = 1'b1;
        end
        OpcLoad: begin
          d.ctrl.alu_src_imm = 1'b1;
          d.ctrl.mem_read    = 1'b1;
          d.ctrl.reg_write   = 1'b1;
          d.ctrl.wb_sel      = WbMem;
          d.ctrl.illegal     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
          d.use_rd           = 1'b1;
          d.use_rs1          = 1'b1;
        end
        OpcStore: begin
          d.ctrl.alu_src_imm = 1'b1;
          d.ctrl.mem_write   = 1'b1;
          d.ctrl.illegal     = f3[2] || (f3 == 3'b011);
          d.use_rs1          = 1'b1;
          d.use_rs2          = 1'b1;
        end
        OpcOpImm: begin
          // funct7 only carries meaning for the shift-immediate forms.
          d.ctrl.alu_op      = alu_decode(f3, (f3 == 3'b101) && f7[5]);
          d.ctrl.alu_src_imm = 1'b1;
          d.ctrl.reg_write   = 1'b1;
          d.ctrl.illegal     = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                               ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
          d.use_rd           = 1'b1;
          d.use_rs1          = 1'b1;
        end
        OpcOp: begin
          d.ctrl.alu_op    = alu_decode(f3, f7[5]);
          d.ctrl.reg_write = 1'b1;
          d.ctrl.illegal   = !((f7 == 7'h00) ||
                               ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
          d.use_rd         = 1'b1;
          d.use_rs1        = 1'b1;
          d.use_rs2        = 1'b1;
        end
        OpcFence, OpcSystem: begin
        end
        default: d.ctrl.illegal = 1'b1;
      endcase
    end
    if (d.ctrl.illegal) begin
      d              = '{ctrl: CtrlBubble, use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b0};
      d.ctrl.illegal = 1'b1;
    end
    return d;
  endfunction

  dec_t             dec;
  logic [4:0]       rs1_idx, rs2_idx, rd_idx;
  logic [Width-1:0] imm, rs1_data, rs2_data;

  ctrl_t            ctrl_q, ctrl_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic [Width-1:0] imm_q, imm_d, pc_q, pc_d, d1_q, d1_d, d2_q, d2_d;

  always_comb begin
    dec     = decode(instructionIn);
    rs1_idx = dec.use_rs1 ? instructionIn[19:15] : 5'd0;
    rs2_idx = dec.use_rs2 ? instructionIn[24:20] : 5'd0;
    rd_idx  = dec.use_rd  ? instructionIn[11:7]  : 5'd0;
    imm     = dec.ctrl.illegal ? '0 : gen_imm(instructionIn);
  end

  eon_reg_file #(
    .Width    (Width),
    .RegCount (RegCount)
  ) u_reg_file (
    .clk    (clk),
    .rstN   (rstN),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .wen    (wbEn),
    .waddr  (wbRd),
    .wdata  (wbData)
  );

  // Unused sources are already forced to x0, so they can never match a nonzero rd.
  assign stallReq = !flush && ctrl_q.mem_read && (rd_q != 5'd0) &&
                    ((rs1_idx == rd_q) || (rs2_idx == rd_q));

  always_comb begin
    ctrl_d = ctrl_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    f3_d   = f3_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    if (flush || (!stall && stallReq)) begin
      ctrl_d = CtrlBubble;
      rs1_d  = '0;
      rs2_d  = '0;
      rd_d   = '0;
      f3_d   = '0;
      imm_d  = '0;
      pc_d   = PCIn;
      d1_d   = '0;
      d2_d   = '0;
    end else if (!stall) begin
      ctrl_d = dec.ctrl;
      rs1_d  = rs1_idx;
      rs2_d  = rs2_idx;
      rd_d   = rd_idx;
      f3_d   = (dec.ctrl == CtrlBubble || dec.ctrl.illegal) ? 3'b000 : instructionIn[14:12];
      imm_d  = imm;
      pc_d   = PCIn;
      d1_d   = rs1_data;
      d2_d   = rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      ctrl_q <= CtrlBubble;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      f3_q   <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      f3_q   <= f3_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
    end
  end

  assign rs1DataOut   = d1_q;
  assign rs2DataOut   = d2_q;
  assign immOut       = imm_q;
  assign rs1Out       = rs1_q;
  assign rs2Out       = rs2_q;
  assign rdOut        = rd_q;
  assign funct3Out    = f3_q;
  assign aluOpOut     = ctrl_q.alu_op;
  assign aluSrcImmOut = ctrl_q.alu_src_imm;
  assign memReadOut   = ctrl_q.mem_read;
  assign memWriteOut  = ctrl_q.mem_write;
  assign regWriteOut  = ctrl_q.reg_write;
  assign branchOut    = ctrl_q.branch;
  assign jumpOut      = ctrl_q.jump;
  assign jalrOut      = ctrl_q.jalr;
  assign illegalOut   = ctrl_q.illegal;
  assign wbSelOut     = ctrl_q.wb_sel;
  assign PCOut        = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage; expected values are hand-computed RV32I encodings.
module tb_id_stage;
  import eon_pkg::*;

  logic        clk = 1'b0;
  logic        rstN, stall, flush, wbEn;
  logic [31:0] instructionIn, PCIn, wbData;
  logic [4:0]  wbRd;
  logic        stallReq;
  logic [31:0] rs1DataOut, rs2DataOut, immOut, PCOut;
  logic [4:0]  rs1Out, rs2Out, rdOut;
  logic [2:0]  funct3Out;
  logic [3:0]  aluOpOut;
  logic        aluSrcImmOut, memReadOut, memWriteOut, regWriteOut;
  logic        branchOut, jumpOut, jalrOut, illegalOut;
  logic [1:0]  wbSelOut;

  always #5 clk = ~clk;

  id_stage dut (
    .clk          (clk),
    .rstN         (rstN),
    .instructionIn(instructionIn),
    .PCIn         (PCIn),
    .stall        (stall),
    .flush        (flush),
    .wbEn         (wbEn),
    .wbRd         (wbRd),
    .wbData       (wbData),
    .stallReq     (stallReq),
    .rs1DataOut   (rs1DataOut),
    .rs2DataOut   (rs2DataOut),
    .immOut       (immOut),
    .rs1Out       (rs1Out),
    .rs2Out       (rs2Out),
    .rdOut        (rdOut),
    .funct3Out    (funct3Out),
    .aluOpOut     (aluOpOut),
    .aluSrcImmOut (aluSrcImmOut),
    .memReadOut   (memReadOut),
    .memWriteOut  (memWriteOut),
    .regWriteOut  (regWriteOut),
    .branchOut    (branchOut),
    .jumpOut      (jumpOut),
    .jalrOut      (jalrOut),
    .illegalOut   (illegalOut),
    .wbSelOut     (wbSelOut),
    .PCOut        (PCOut)
  );

`ifdef EON_WB_BYPASS_EN
  localparam logic [31:0] SameCycleX5 = 32'hCAFEF00D;
`else
  localparam logic [31:0] SameCycleX5 = 32'hDEADBEEF;
`endif

  localparam logic [31:0] IAddi = 32'h00028093;  // addi x1,x5,0
  localparam logic [31:0] ILw   = 32'h00012183;  // lw x3,0(x2)
  localparam logic [31:0] IAdd  = 32'h00118233;  // add x4,x3,x1

  typedef struct {
    logic [31:0] instr, pc;
    logic        flush, wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        e_stall;
    logic [7:0]  e_flags;
    aluop_t      e_alu;
    wbsel_t      e_wb;
    logic [31:0] e_imm;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [31:0] e_pc, e_d1, e_d2;
    logic [2:0]  e_f3;
  } vec_t;

  vec_t vecs [19];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [31:0] instr, pc, input logic fl, we,
                              input logic [4:0] wrd, input logic [31:0] wdat, input logic est,
                              input logic [7:0] efl, input aluop_t ealu, input wbsel_t ewb,
                              input logic [31:0] eimm, input logic [4:0] erd, ers1, ers2,
                              input logic [31:0] epc, ed1, ed2, input logic [2:0] ef3);
    vec_t v;
    v = '{instr, pc, fl, we, wrd, wdat, est, efl, ealu, ewb, eimm, erd, ers1, ers2,
          epc, ed1, ed2, ef3};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {aluSrcImmOut, memReadOut, memWriteOut, regWriteOut,
            branchOut, jumpOut, jalrOut, illegalOut};
  endfunction

  task automatic drive(input logic [31:0] instr, pc, input logic st, fl, we,
                       input logic [4:0] wrd, input logic [31:0] wdat);
    instructionIn = instr;
    PCIn          = pc;
    stall         = st;
    flush         = fl;
    wbEn          = we;
    wbRd          = wrd;
    wbData        = wdat;
  endtask

  initial begin
    // Flags order: {src_imm, mem_rd, mem_wr, reg_wr, branch, jump, jalr, illegal}
    vecs[0]  = mk(NOP_INSTR, 32'h100, 0, 1, 5, 32'hDEADBEEF, 0, 8'h00, AluAdd, WbAlu,
                  0, 0, 0, 0, 32'h100, 0, 0, 0);
    vecs[1]  = mk(IAddi, 32'h104, 0, 1, 2, 32'h00001000, 0, 8'h90, AluAdd, WbAlu,
                  0, 1, 5, 0, 32'h104, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(IAddi, 32'h108, 0, 1, 5, 32'hCAFEF00D, 0, 8'h90, AluAdd, WbAlu,
                  0, 1, 5, 0, 32'h108, SameCycleX5, 0, 0);
    vecs[3]  = mk(ILw, 32'h10C, 0, 1, 1, 32'h11111111, 0, 8'hD0, AluAdd, WbMem,
                  0, 3, 2, 0, 32'h10C, 32'h00001000, 0, 2);
    vecs[4]  = mk(IAdd, 32'h110, 0, 1, 3, 32'h33333333, 1, 8'h00, AluAdd, WbAlu,
                  0, 0, 0, 0, 32'h110, 0, 0, 0);
    vecs[5]  = mk(IAdd, 32'h110, 0, 0, 0, 0, 0, 8'h10, AluAdd, WbAlu,
                  0, 4, 3, 1, 32'h110, 32'h33333333, 32'h11111111, 0);
    vecs[6]  = mk(32'hFE000EE3, 32'h114, 0, 0, 0, 0, 0, 8'h08, AluSub, WbAlu,
                  32'hFFFFFFFC, 0, 0, 0, 32'h114, 0, 0, 0);
    vecs[7]  = mk(32'hFE000EE3, 32'h118, 1, 0, 0, 0, 0, 8'h00, AluAdd, WbAlu,
                  0, 0, 0, 0, 32'h118, 0, 0, 0);
    vecs[8]  = mk(32'hFFFFFFFF, 32'h11C, 0, 1, 0, 32'hFFFFFFFF, 0, 8'h01, AluAdd, WbAlu,
                  0, 0, 0, 0, 32'h11C, 0, 0, 0);
    vecs[9]  = mk(32'h000003B3, 32'h120, 0, 1, 0, 32'hAAAA5555, 0, 8'h10, AluAdd, WbAlu,
                  0, 7, 0, 0, 32'h120, 0, 0, 0);
    vecs[10] = mk(32'h00512423, 32'h124, 0, 0, 0, 0, 0, 8'hA0, AluAdd, WbAlu,
                  8, 0, 2, 5, 32'h124, 32'h00001000, 32'hCAFEF00D, 2);
    vecs[11] = mk(32'h12345537, 32'h128, 0, 0, 0, 0, 0, 8'h90, AluPassB, WbAlu,
                  32'h12345000, 10, 0, 0, 32'h128, 0, 0, 5);
    vecs[12] = mk(32'h010000EF, 32'h12C, 0, 0, 0, 0, 0, 8'h94, AluAdd, WbPc4,
                  16, 1, 0, 0, 32'h12C, 0, 0, 0);
    vecs[13] = mk(32'h00008067, 32'h130, 0, 0, 0, 0, 0, 8'h92, AluAdd, WbPc4,
                  0, 0, 1, 0, 32'h130, 32'h11111111, 0, 0);
    vecs[14] = mk(32'h4042D313, 32'h134, 0, 0, 0, 0, 0, 8'h90, AluSra, WbAlu,
                  32'h404, 6, 5, 0, 32'h134, 32'hCAFEF00D, 0, 5);
    vecs[15] = mk(32'h40508433, 32'h138, 0, 0, 0, 0, 0, 8'h10, AluSub, WbAlu,
                  0, 8, 1, 5, 32'h138, 32'h11111111, 32'hCAFEF00D, 0);
    vecs[16] = mk(32'h00000073, 32'h13C, 0, 0, 0, 0, 0, 8'h00, AluAdd, WbAlu,
                  0, 0, 0, 0, 32'h13C, 0, 0, 0);
    vecs[17] = mk(32'h02000033, 32'h140, 0, 0, 0, 0, 0, 8'h01, AluAdd, WbAlu,
                  0, 0, 0, 0, 32'h140, 0, 0, 0);
    vecs[18] = mk(32'h00001497, 32'h144, 0, 0, 0, 0, 0, 8'h90, AluAdd, WbAlu,
                  32'h1000, 9, 0, 0, 32'h144, 0, 0, 1);

    // Reset with a load presented so a stuck decode would show.
    rstN = 1'b0;
    drive(ILw, 32'h55, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.flags", 32'(flags()), 0);
    check("rst.pc", PCOut, 0);
    check("rst.rs1data", rs1DataOut, 0);
    check("rst.rd", 32'(rdOut), 0);
    check("rst.imm", immOut, 0);
    check("rst.aluop", 32'(aluOpOut), 32'(AluAdd));
    check("rst.stallreq", 32'(stallReq), 0);
    rstN = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc, 0, vecs[i].flush, vecs[i].wb_en, vecs[i].wb_rd,
            vecs[i].wb_data);
      #1;
      check($sformatf("v%0d.stallreq", i), 32'(stallReq), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("v%0d.flags", i), 32'(flags()), 32'(vecs[i].e_flags));
      check($sformatf("v%0d.aluop", i), 32'(aluOpOut), 32'(vecs[i].e_alu));
      check($sformatf("v%0d.wbsel", i), 32'(wbSelOut), 32'(vecs[i].e_wb));
      check($sformatf("v%0d.imm", i), immOut, vecs[i].e_imm);
      check($sformatf("v%0d.rd", i), 32'(rdOut), 32'(vecs[i].e_rd));
      check($sformatf("v%0d.rs1", i), 32'(rs1Out), 32'(vecs[i].e_rs1));
      check($sformatf("v%0d.rs2", i), 32'(rs2Out), 32'(vecs[i].e_rs2));
      check($sformatf("v%0d.pc", i), PCOut, vecs[i].e_pc);
      check($sformatf("v%0d.rs1data", i), rs1DataOut, vecs[i].e_d1);
      check($sformatf("v%0d.rs2data", i), rs2DataOut, vecs[i].e_d2);
      check($sformatf("v%0d.funct3", i), 32'(funct3Out), 32'(vecs[i].e_f3));
    end

    // stall freezes outputs while the register file still takes writes.
    @(negedge clk);
    drive(IAddi, 32'h200, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("stall.pre.rs1data", rs1DataOut, 32'hCAFEF00D);
    @(negedge clk);
    drive(32'h12345537, 32'h204, 1, 0, 1, 5, 32'h55AA55AA);
    @(posedge clk);
    #1;
    check("stall.hold.pc", PCOut, 32'h200);
    check("stall.hold.rd", 32'(rdOut), 1);
    check("stall.hold.flags", 32'(flags()), 32'h90);
    check("stall.hold.rs1data", rs1DataOut, 32'hCAFEF00D);
    @(negedge clk);
    drive(IAddi, 32'h208, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("stall.post.rs1data", rs1DataOut, 32'h55AA55AA);
    check("stall.post.pc", PCOut, 32'h208);

    // Hazard under stall holds the load; flush then masks the request.
    @(negedge clk);
    drive(ILw, 32'h300, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("hz.lw.memread", 32'(memReadOut), 1);
    @(negedge clk);
    drive(IAdd, 32'h304, 1, 0, 0, 0, 0);
    #1;
    check("hz.stall.stallreq", 32'(stallReq), 1);
    @(posedge clk);
    #1;
    check("hz.stall.flags", 32'(flags()), 32'hD0);
    check("hz.stall.pc", PCOut, 32'h300);
    @(negedge clk);
    drive(IAdd, 32'h304, 0, 1, 0, 0, 0);
    #1;
    check("hz.flush.stallreq", 32'(stallReq), 0);
    @(posedge clk);
    #1;
    check("hz.flush.flags", 32'(flags()), 0);
    check("hz.flush.rd", 32'(rdOut), 0);
    check("hz.flush.pc", PCOut, 32'h304);
    @(negedge clk);
    drive(IAdd, 32'h304, 0, 0, 0, 0, 0);
    #1;
    check("hz.after.stallreq", 32'(stallReq), 0);
    @(posedge clk);
    #1;
    check("hz.after.rd", 32'(rdOut), 4);

    // Reset during a hazard clears the request and the register file.
    @(negedge clk);
    drive(ILw, 32'h400, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(IAdd, 32'h404, 0, 0, 0, 0, 0);
    #1;
    check("rsthz.pre.stallreq", 32'(stallReq), 1);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    check("rsthz.stallreq", 32'(stallReq), 0);
    check("rsthz.pc", PCOut, 0);
    check("rsthz.flags", 32'(flags()), 0);
    @(negedge clk);
    rstN = 1'b1;
    drive(IAddi, 32'h408, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("rsthz.x5cleared", rs1DataOut, 0);
    check("rsthz.rd", 32'(rdOut), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
